// File: rtl/rgb_status_uart_tx.sv
// Encodes the RGB LED state into the LED command alphabet and sends it as one 8N1 UART frame.
// Requests that arrive mid-frame collapse into one queued frame, which re-samples rgb_in_i when it starts.
module rgb_status_uart_tx #(
  parameter int unsigned CLKS_PER_BIT   = 104,
  parameter bit          AUTO_ON_CHANGE = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [2:0] rgb_in_i,
  input  logic       send_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      byte_q, byte_d;
  logic            pending_q, pending_d;
  logic [2:0]      last_q, last_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            req;
  logic            bit_end;
  logic [2:0]      nxt_bit;

  function automatic logic [7:0] encode(input logic [2:0] rgb);
    case (rgb)
      3'b100:  encode = 8'h41;
      3'b010:  encode = 8'h42;
      3'b001:  encode = 8'h43;
      3'b110:  encode = 8'h44;
      3'b011:  encode = 8'h45;
      3'b101:  encode = 8'h46;
      3'b000:  encode = 8'h30;
      default: encode = 8'h3F;
    endcase
  endfunction

  assign req     = send_i | (AUTO_ON_CHANGE && (rgb_in_i != last_q));
  assign bit_end = (cnt_q == CntLast);
  assign nxt_bit = bit_q + 3'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    pending_d = pending_q;
    last_d    = last_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          byte_d  = encode(rgb_in_i);
          last_d  = rgb_in_i;
          state_d = StStart;
          cnt_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      StStart: begin
        pending_d = pending_q | req;
        if (bit_end) begin
          state_d = StData;
          cnt_d   = '0;
          bit_d   = 3'd0;
          tx_d    = byte_q[0];
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        pending_d = pending_q | req;
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d = nxt_bit;
            tx_d  = byte_q[nxt_bit];
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        pending_d = pending_q | req;
        if (bit_end) begin
          done_d = 1'b1;
          cnt_d  = '0;
          // A request landing in the last stop cycle counts as pending: no idle gap.
          if (pending_q || req) begin
            pending_d = 1'b0;
            byte_d    = encode(rgb_in_i);
            last_d    = rgb_in_i;
            state_d   = StStart;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      byte_q    <= 8'h00;
      pending_q <= 1'b0;
      last_q    <= 3'b000;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      pending_q <= pending_d;
      last_q    <= last_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule
